// File: rtl/param_bus_datapath.sv
// Parametrised single-bus ALU datapath with Y/Z staging, HI/LO and its own T-state sequencer.
// Ops arrive on a valid/ready handshake; each result is posted on a one-cycle strobe.
module param_bus_datapath #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              stop,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [4:0]        op_ra,
  input  logic [4:0]        op_rb,
  input  logic [4:0]        op_rc,
  input  logic              op_use_imm,
  input  logic [DATA_W-1:0] op_imm,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0]      NREGS = 6'(NUM_REGS);
  localparam logic [SH_W:0]   WBITS = (SH_W + 1)'(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4,  OP_SHR  = 4'd5,  OP_SHRA = 4'd6,  OP_ROL  = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8,  OP_NEG  = 4'd9,  OP_NOT  = 4'd10, OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12, OP_MFLO = 4'd13, OP_NOP = 4'd14;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_Y, S_EXEC, S_WB, S_WB_HI} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   y, hi, lo;
  logic [2*DATA_W-1:0] z, z_next;
  logic [3:0]          code_q;
  logic [4:0]          ra_q, rb_q, rc_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   imm_q;

  function automatic logic in_range(input logic [4:0] idx);
    return ({1'b0, idx} < NREGS);
  endfunction

  // Out-of-range indices read as zero
  logic [DATA_W-1:0] ra_val, rb_val, b_op;
  always_comb begin
    ra_val   = '0;
    rb_val   = '0;
    dbg_data = '0;
    if (in_range(ra_q))     ra_val   = regs[ra_q[IDX_W-1:0]];
    if (in_range(rb_q))     rb_val   = regs[rb_q[IDX_W-1:0]];
    if (in_range(dbg_addr)) dbg_data = regs[dbg_addr[IDX_W-1:0]];
    b_op = use_imm_q ? imm_q : rb_val;
  end

  logic uses_a, uses_b, writes, err, wr_en;
  always_comb begin
    uses_a = (code_q <= OP_ROR) || (code_q == OP_MUL);
    uses_b = (code_q <= OP_MUL);
    writes = (code_q <= OP_MFLO);
    err    = (code_q == 4'd15)
           || (uses_a && !in_range(ra_q))
           || (uses_b && !use_imm_q && !in_range(rb_q))
           || (writes && !in_range(rc_q));
    wr_en  = writes && !err && !(R0_ZERO && (rc_q == 5'd0));
  end

  logic [SH_W-1:0]            shamt;
  logic [SH_W:0]              shinv;
  logic [DATA_W-1:0]          alu;
  logic signed [2*DATA_W-1:0] prod;
  always_comb begin
    shamt  = b_op[SH_W-1:0];
    shinv  = WBITS - {1'b0, shamt};
    prod   = $signed({{DATA_W{y[DATA_W-1]}}, y}) * $signed({{DATA_W{b_op[DATA_W-1]}}, b_op});
    alu    = '0;
    case (code_q)
      OP_ADD:  alu = y + b_op;
      OP_SUB:  alu = y - b_op;
      OP_AND:  alu = y & b_op;
      OP_OR:   alu = y | b_op;
      OP_SHL:  alu = y << shamt;
      OP_SHR:  alu = y >> shamt;
      OP_SHRA: alu = DATA_W'($signed(y) >>> shamt);
      OP_ROL:  alu = (y << shamt) | (y >> shinv);
      OP_ROR:  alu = (y >> shamt) | (y << shinv);
      OP_NEG:  alu = -b_op;
      OP_NOT:  alu = ~b_op;
      OP_MFHI: alu = hi;
      OP_MFLO: alu = lo;
      default: alu = '0;
    endcase
    z_next = (code_q == OP_MUL) ? prod : {DATA_W'(0), alu};
  end

  // T-state sequencer
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      op_ready <= 1'b1;
    end else if (!stop) begin
      state    <= state_next;
      op_ready <= (state_next == S_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (op_valid) state_next = S_LOAD_Y;
      S_LOAD_Y: state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = (code_q == OP_MUL) ? S_WB_HI : S_IDLE;
      S_WB_HI:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath registers; everything holds while stop is high
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      y         <= '0;
      z         <= '0;
      hi        <= '0;
      lo        <= '0;
      code_q    <= OP_NOP;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
    end else if (!stop) begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: if (op_valid) begin
          code_q    <= op_code;
          ra_q      <= op_ra;
          rb_q      <= op_rb;
          rc_q      <= op_rc;
          use_imm_q <= op_use_imm;
          imm_q     <= op_imm;
        end
        S_LOAD_Y: y <= ra_val;
        S_EXEC:   z <= z_next;
        S_WB: begin
          if (wr_en) regs[rc_q[IDX_W-1:0]] <= z[DATA_W-1:0];
          if (code_q == OP_MUL) begin
            if (!err) lo <= z[DATA_W-1:0];
          end else begin
            res_valid <= 1'b1;
            res_data  <= z[DATA_W-1:0];
            res_err   <= err;
            if (writes && !err) begin
              flag_z <= (z[DATA_W-1:0] == '0);
              flag_n <= z[DATA_W-1];
            end
          end
        end
        S_WB_HI: begin
          if (!err) begin
            hi     <= z[2*DATA_W-1:DATA_W];
            flag_z <= (z[DATA_W-1:0] == '0);
            flag_n <= z[DATA_W-1];
          end
          res_valid <= 1'b1;
          res_data  <= z[DATA_W-1:0];
          res_err   <= err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed and random checks of param_bus_datapath against an arithmetic reference model.
module tb_param_bus_datapath;
  logic        clock = 1'b0;
  logic        clear, stop, op_valid, op_ready, op_use_imm;
  logic [3:0]  op_code;
  logic [4:0]  op_ra, op_rb, op_rc, dbg_addr;
  logic [31:0] op_imm, res_data, dbg_data;
  logic        res_valid, res_err, flag_z, flag_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_hi, m_lo;
  logic        m_z, m_n;

  param_bus_datapath #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1'b1)) dut (
    .clock(clock), .clear(clear), .stop(stop), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_ra(op_ra), .op_rb(op_rb), .op_rc(op_rc), .op_use_imm(op_use_imm),
    .op_imm(op_imm), .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .flag_z(flag_z), .flag_n(flag_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_z = 1'b0; m_n = 1'b0;
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) dbg_chk($sformatf("dbg_r%0d", i), 5'(i), m_regs[i]);
    dbg_chk("dbg_oob", 5'($urandom_range(16, 31)), 32'h0);
  endtask

  task automatic run_op(input logic [3:0] code, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rc, input logic ui, input logic [31:0] imm,
                        input int stall_k);
    logic [31:0] a, b, res;
    logic [63:0] p;
    logic [4:0]  s;
    logic        err, uses_a, uses_b, writes;
    int          lat, k;
    a = (ra < 16) ? m_regs[ra[3:0]] : 32'h0;
    b = ui ? imm : ((rb < 16) ? m_regs[rb[3:0]] : 32'h0);
    s = b[4:0];
    p = 64'h0;
    case (code)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a << s;
      4'd5:  res = a >> s;
      4'd6:  res = $signed(a) >>> s;
      4'd7:  res = (a << s) | (a >> (32 - s));
      4'd8:  res = (a >> s) | (a << (32 - s));
      4'd9:  res = -b;
      4'd10: res = ~b;
      4'd11: begin p = longint'($signed(a)) * longint'($signed(b)); res = p[31:0]; end
      4'd12: res = m_hi;
      4'd13: res = m_lo;
      default: res = 32'h0;
    endcase
    uses_a = (code <= 4'd8) || (code == 4'd11);
    uses_b = (code <= 4'd11);
    writes = (code <= 4'd13);
    err = (code == 4'd15) || (uses_a && ra >= 16) || (uses_b && !ui && rb >= 16) || (writes && rc >= 16);
    if (writes && !err) begin
      if (code == 4'd11) begin m_lo = p[31:0]; m_hi = p[63:32]; end
      if (rc != 5'd0) m_regs[rc[3:0]] = res;
      m_z = (res == 32'h0);
      m_n = res[31];
    end
    lat = ((code == 4'd11) ? 4 : 3) + ((stall_k >= 0) ? 3 : 0);

    @(negedge clock);
    k = 0;
    while (!op_ready && k < 20) begin @(negedge clock); k++; end
    chk("ready_before_issue", 32'(op_ready), 32'h1);
    op_code = code; op_ra = ra; op_rb = rb; op_rc = rc; op_use_imm = ui; op_imm = imm;
    op_valid = 1'b1;
    @(negedge clock);
    op_valid = 1'b0;
    chk("ready_low_after_accept", 32'(op_ready), 32'h0);
    k = 0;
    while (!res_valid && k < 30) begin
      if (k == 0) begin
        op_valid = 1'b1;
        op_code = 4'($urandom); op_rc = 5'($urandom); op_imm = $urandom; op_ra = 5'($urandom);
      end
      if (k == 1) op_valid = 1'b0;
      if (k == stall_k) stop = 1'b1;
      if (k == stall_k + 3) stop = 1'b0;
      @(negedge clock);
      k++;
    end
    op_valid = 1'b0;
    stop = 1'b0;
    chk("latency", 32'(k), 32'(lat));
    chk("ready_at_result", 32'(op_ready), 32'h1);
    chk("res_err", 32'(res_err), 32'(err));
    if (!err) chk("res_data", res_data, res);
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("flag_n", 32'(flag_n), 32'(m_n));
    @(negedge clock);
    chk("strobe_width", 32'(res_valid), 32'h0);
    if (!err) chk("res_data_held", res_data, res);
    check_regs();
  endtask

  function automatic logic [4:0] rand_idx();
    return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
  endfunction

  initial begin
    int  k;
    logic seen;
    clear = 1'b0; stop = 1'b0; op_valid = 1'b0; op_code = 4'd0; op_ra = 5'd0; op_rb = 5'd0;
    op_rc = 5'd0; op_use_imm = 1'b0; op_imm = 32'h0; dbg_addr = 5'd0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(op_ready), 32'h1);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_flags", {30'h0, flag_z, flag_n}, 32'h0);
    clear = 1'b1;
    check_regs();

    run_op(4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, -1);
    dbg_chk("add_r1", 5'd1, 32'd5);
    run_op(4'd1, 5'd1, 5'd0, 5'd2, 1'b1, 32'd7, -1);
    dbg_chk("sub_r2", 5'd2, 32'hFFFF_FFFE);
    chk("sub_flag_n", 32'(flag_n), 32'h1);

    run_op(4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h0001_0000, -1);
    run_op(4'd11, 5'd1, 5'd0, 5'd3, 1'b1, 32'h0001_0000, -1);
    dbg_chk("mul_r3", 5'd3, 32'h0);
    chk("mul_flag_z", 32'(flag_z), 32'h1);
    run_op(4'd12, 5'd0, 5'd0, 5'd4, 1'b0, 32'h0, -1);
    dbg_chk("mfhi_r4", 5'd4, 32'h1);
    run_op(4'd13, 5'd0, 5'd0, 5'd7, 1'b0, 32'h0, -1);
    dbg_chk("mflo_r7", 5'd7, 32'h0);

    run_op(4'd0, 5'd0, 5'd0, 5'd5, 1'b1, 32'd1, -1);
    run_op(4'd8, 5'd5, 5'd0, 5'd5, 1'b1, 32'd33, -1);
    dbg_chk("ror_r5", 5'd5, 32'h8000_0000);
    run_op(4'd6, 5'd5, 5'd0, 5'd5, 1'b1, 32'd4, -1);
    dbg_chk("shra_r5", 5'd5, 32'hF800_0000);

    run_op(4'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd9, -1);
    dbg_chk("r0_zero", 5'd0, 32'h0);
    chk("r0_res_data", res_data, 32'd9);
    run_op(4'd0, 5'd1, 5'd0, 5'd16, 1'b1, 32'd9, -1);
    chk("oob_err", 32'(res_err), 32'h1);
    run_op(4'd14, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, -1);
    chk("nop_data", res_data, 32'h0);
    run_op(4'd15, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, -1);
    chk("illegal_err", 32'(res_err), 32'h1);

    run_op(4'd0, 5'd1, 5'd0, 5'd6, 1'b1, 32'd3, 1);
    dbg_chk("stall_r6", 5'd6, 32'h0001_0003);

    // Reset while the ADD to R6 is in EXEC
    @(negedge clock);
    op_code = 4'd0; op_ra = 5'd0; op_rc = 5'd6; op_use_imm = 1'b1; op_imm = 32'h55; op_valid = 1'b1;
    @(negedge clock);
    op_valid = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    model_reset();
    @(negedge clock);
    clear = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (res_valid) seen = 1'b1;
    end
    chk("midop_no_strobe", 32'(seen), 32'h0);
    chk("midop_ready", 32'(op_ready), 32'h1);
    chk("midop_res_data", res_data, 32'h0);
    dbg_chk("midop_r6", 5'd6, 32'h0);
    check_regs();

    for (int n = 0; n < 40; n++) begin
      k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_op(4'($urandom_range(0, 15)), rand_idx(), rand_idx(), rand_idx(), 1'($urandom),
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom, k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
